// File: rtl/pb_event_blinker_if.sv
// Event/LED bundle for pb_event_blinker.
//   evt  : single-cycle event strobe, synchronous to the clock of the block
//   clr  : synchronous clear (abort blink, flush backlog, clear ovf)
//   led  : registered LED drive, active high
//   busy : blink in progress or events still queued
//   pend : number of queued events not yet started
//   ovf  : sticky flag, an event was dropped because pend was saturated
// master = event source side, slave = blinker side.
interface pb_event_blinker_if #(
  parameter int PEND_W = 4
);
  logic              evt;
  logic              clr;
  logic              led;
  logic              busy;
  logic [PEND_W-1:0] pend;
  logic              ovf;

  modport master (
    output evt, clr,
    input  led, busy, pend, ovf
  );

  modport slave (
    input  evt, clr,
    output led, busy, pend, ovf
  );
endinterface

// File: rtl/pb_event_blinker.sv
// pb_event_blinker: turns single-cycle events into human-visible LED blinks.
// Each event yields exactly one blink of ON_CYC cycles high followed by
// OFF_CYC cycles low. Events arriving while a blink runs are counted in a
// saturating backlog; a drop at saturation sets the sticky ovf flag.
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : slave modport of pb_event_blinker_if (evt, clr in; led, busy,
//           pend, ovf out)
module pb_event_blinker #(
  parameter int ON_CYC  = 4,
  parameter int OFF_CYC = 4,
  parameter int PEND_W  = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  pb_event_blinker_if.slave  bus
);

  localparam int MAX_CYC = (ON_CYC > OFF_CYC) ? ON_CYC : OFF_CYC;
  localparam int TW      = $clog2(MAX_CYC) + 1;

  localparam logic [TW-1:0]     ON_LD    = TW'(ON_CYC - 1);
  localparam logic [TW-1:0]     OFF_LD   = TW'(OFF_CYC - 1);
  localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [PEND_W-1:0] pend_q,  pend_d;
  logic              ovf_q,   ovf_d;
  logic              led_q,   led_d;
  logic              start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      timer_q <= '0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
      led_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      led_q   <= led_d;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    pend_d  = pend_q;
    ovf_d   = ovf_q;
    start   = 1'b0;

    if (bus.clr) begin
      // Clear wins over everything, including an evt in the same cycle.
      state_d = IDLE;
      timer_d = '0;
      pend_d  = '0;
      ovf_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          // An idle event starts its blink directly and never enters pend.
          if (bus.evt) begin
            state_d = ON;
            timer_d = ON_LD;
          end
        end
        ON: begin
          if (timer_q != '0) begin
            timer_d = timer_q - TW'(1);
          end else begin
            state_d = OFF;
            timer_d = OFF_LD;
          end
        end
        OFF: begin
          if (timer_q != '0) begin
            timer_d = timer_q - TW'(1);
          end else if ((pend_q != '0) || bus.evt) begin
            // Back-to-back blink: no IDLE cycle in between.
            start   = 1'b1;
            state_d = ON;
            timer_d = ON_LD;
          end else begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
          timer_d = '0;
        end
      endcase

      // Backlog accounting. A start with pend==0 consumes the coincident evt;
      // a start with pend!=0 and evt nets to zero change.
      if (start) begin
        if ((pend_q != '0) && !bus.evt) begin
          pend_d = pend_q - PEND_W'(1);
        end
      end else if (bus.evt && (state_q != IDLE)) begin
        if (pend_q != PEND_MAX) begin
          pend_d = pend_q + PEND_W'(1);
        end else begin
          ovf_d = 1'b1;
        end
      end
    end

    // LED is a flop that mirrors the next state, so it is high exactly in ON.
    led_d = (state_d == ON);
  end

  assign bus.led  = led_q;
  assign bus.pend = pend_q;
  assign bus.ovf  = ovf_q;
  assign bus.busy = (state_q != IDLE) || (pend_q != '0);

endmodule

// File: doc/pb_event_blinker.md
Name: pb_event_blinker

Overview:
- Output-direction companion to the push-button input path.
- Input side turns a slow human action into a single-cycle event. This block turns single-cycle events back into human-visible LED blinks of fixed on/off length.
- Events that arrive while a blink is in progress are queued, so every event gives exactly one blink, up to a saturation limit.
- Sits between event sources (button release, cmd-done strobes) and board LEDs.

Parameters:
ON_CYC, 4, clk cycles LED held high per blink; legal range >= 1
OFF_CYC, 4, clk cycles LED held low after each blink before the next may start; legal range >= 1
PEND_W, 4, width of pending-event counter; saturates at 2^PEND_W-1

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
evt  input  1  single-cycle event strobe, already synchronous to clk
clr  input  1  synchronous clear; aborts blink, flushes queue, clears ovf
led  output  1  registered LED drive, active high
busy  output  1  high when state != IDLE or pend != 0
pend  output  PEND_W  queued events not yet started
ovf  output  1  sticky; set when an event is dropped at saturation

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk. On reset: state=IDLE, led=0, timer=0, pend=0, ovf=0, busy=0.
- States: IDLE, ON, OFF.
- Single down-counter timer, width clog2(max(ON_CYC,OFF_CYC))+1.
- led is a flop: led=1 exactly while state=ON.
- IDLE:
  - evt=1 -> ON, timer=ON_CYC-1.
  - pend is unchanged (event consumed directly).
  - led goes high on the edge that samples evt; latency 1 edge.
- ON:
  - timer!=0 -> timer-1.
  - timer==0 -> OFF, timer=OFF_CYC-1.
  - led is therefore high for exactly ON_CYC cycles.
- OFF:
  - timer!=0 -> timer-1.
  - timer==0 and (pend!=0 or evt) -> ON, timer=ON_CYC-1.
  - timer==0 and pend==0 and evt==0 -> IDLE.
  - led is low for exactly OFF_CYC cycles between blinks.
- Blink period with a backlog is ON_CYC+OFF_CYC cycles.
- pend update, evaluated each cycle with start = OFF->ON transition:
  - start and pend!=0 and evt: pend unchanged (+1-1).
  - start and pend!=0 and !evt: pend-1.
  - start and pend==0 (must be evt): pend stays 0.
  - no start, evt, not in IDLE: pend+1 if pend < 2^PEND_W-1. Otherwise hold and set ovf=1.
  - An IDLE-state evt never touches pend.
- ovf stays set until clr or reset.
- clr (synchronous, highest priority over all other updates):
  - next edge: state=IDLE, led=0, timer=0, pend=0, ovf=0.
  - evt in the same cycle as clr is discarded.
- busy is combinational from registers: (state!=IDLE) | (pend!=0).
- Reset asserted mid-blink: all outputs go to reset values immediately (asynchronously). First evt after deassertion behaves as from IDLE.
- evt held high for multiple cycles counts as one event per cycle. Callers guarantee single-cycle strobes.

Test Plan:
1. Defaults, one evt at edge E0 -> led=1 after E0 through E3, led=0 after E4, busy high 8 cycles, IDLE after E8, pend stays 0.
2. evt at E0, then evt at E1 and E2 (during ON) -> pend 1 then 2, three blinks with led rising at E0, E8 and E16, pend 1 after E8 and 0 after E16, busy low after E24.
3. PEND_W=2, evt at E0 plus 5 evts during the first blink -> pend saturates at 3, ovf=1 after the 4th queued evt, exactly 4 blinks total, ovf still 1 at end.
4. evt on the final OFF cycle (timer==0) with pend=0 -> next edge led=1, pend=0, no IDLE cycle. Repeat with pend=2 -> led=1, pend remains 2.
5. clr mid-ON with pend=2 and ovf=1, evt asserted in the same cycle -> next edge led=0, pend=0, ovf=0, busy=0, state IDLE. A later single evt gives exactly one blink.
6. rst_n pulsed low mid-blink between clock edges -> led, busy and pend go to 0 without a clock edge. After release, one evt gives one normal 4-cycle blink.
